// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg: shared encodings for the multicycle control FSM and the
// downstream ALU decoder (state codes, opcodes, ALUOp class codes and the
// datapath mux-select encodings).
// Optional build macro: MAIN_FSM_TRAP_EN adds the TRAP state.
package main_fsm_pkg;

  // Controller states, 4-bit encoding
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
`ifdef MAIN_FSM_TRAP_EN
    ,
    TRAP     = 4'd11
`endif
  } state_t;

  // Opcodes recognised in DECODE
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // ALUOp class codes; 2'b11 is reserved and never driven
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Full control word produced for one state
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = 15'd0;

  // Loads and stores share the address-generation path
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// main_fsm_outdec: combinational state-to-control-word decoder. Outputs are
// Moore except for the MemReady gating of the FETCH strobes and of InstrDone
// in MEMWRITE. Optional build macro: MAIN_FSM_TRAP_EN (adds IllegalOp).
import main_fsm_pkg::*;

module main_fsm_outdec (
  input  state_t     state,
  input  logic       MemReady,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       InstrDone
`ifdef MAIN_FSM_TRAP_EN
  ,
  output logic       IllegalOp
`endif
);

  ctrl_t ctrl_s;

  // Decode the current state into the control word; everything idle by default
  always_comb begin
    ctrl_s = CTRL_IDLE;
    case (state)
      FETCH: begin
        ctrl_s.adr_src    = 1'b0;
        ctrl_s.alu_src_a  = SRCA_PC;
        ctrl_s.alu_src_b  = SRCB_FOUR;
        ctrl_s.alu_op     = ALUOP_ADD;
        ctrl_s.result_src = RES_ALU;
        ctrl_s.ir_write   = MemReady;
        ctrl_s.pc_update  = MemReady;
      end
      DECODE: begin
        ctrl_s.alu_src_a = SRCA_OLDPC;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl_s.alu_src_a = SRCA_REG;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl_s.adr_src    = 1'b1;
        ctrl_s.result_src = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl_s.result_src = RES_DATA;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      MEMWRITE: begin
        ctrl_s.adr_src    = 1'b1;
        ctrl_s.result_src = RES_ALUOUT;
        ctrl_s.mem_write  = 1'b1;
        ctrl_s.instr_done = MemReady;
      end
      EXECUTER: begin
        ctrl_s.alu_src_a = SRCA_REG;
        ctrl_s.alu_src_b = SRCB_REG;
        ctrl_s.alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ctrl_s.alu_src_a = SRCA_REG;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl_s.result_src = RES_ALUOUT;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      BEQ: begin
        ctrl_s.alu_src_a  = SRCA_REG;
        ctrl_s.alu_src_b  = SRCB_REG;
        ctrl_s.alu_op     = ALUOP_SUB;
        ctrl_s.result_src = RES_ALUOUT;
        ctrl_s.branch     = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      JAL: begin
        ctrl_s.alu_src_a  = SRCA_OLDPC;
        ctrl_s.alu_src_b  = SRCB_FOUR;
        ctrl_s.alu_op     = ALUOP_ADD;
        ctrl_s.result_src = RES_ALUOUT;
        ctrl_s.pc_update  = 1'b1;
      end
      default: ctrl_s = CTRL_IDLE;
    endcase
  end

  assign PCUpdate  = ctrl_s.pc_update;
  assign Branch    = ctrl_s.branch;
  assign RegWrite  = ctrl_s.reg_write;
  assign MemWrite  = ctrl_s.mem_write;
  assign IRWrite   = ctrl_s.ir_write;
  assign AdrSrc    = ctrl_s.adr_src;
  assign ResultSrc = ctrl_s.result_src;
  assign ALUSrcA   = ctrl_s.alu_src_a;
  assign ALUSrcB   = ctrl_s.alu_src_b;
  assign ALUOp     = ctrl_s.alu_op;
  assign InstrDone = ctrl_s.instr_done;

`ifdef MAIN_FSM_TRAP_EN
  // TRAP is only left through reset, so decoding it gives a sticky flag
  assign IllegalOp = (state == TRAP);
`endif

endmodule

// File: rtl/main_fsm.sv
// main_fsm: multicycle processor control FSM. Holds the state register and
// next-state logic; the control word comes from main_fsm_outdec.
// Optional build macro: MAIN_FSM_TRAP_EN (unknown opcodes trap, IllegalOp port).
import main_fsm_pkg::*;

module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       InstrDone
`ifdef MAIN_FSM_TRAP_EN
  ,
  output logic       IllegalOp
`endif
);

  state_t state_r;
  state_t next_state_s;

  // State register; reset abandons any instruction and returns to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection from current state, opcode and memory handshake
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH: begin
        if (MemReady) next_state_s = DECODE;
        else          next_state_s = FETCH;
      end
      DECODE: begin
        if (is_mem_op(op))        next_state_s = MEMADR;
        else if (op == OP_RTYPE)  next_state_s = EXECUTER;
        else if (op == OP_ITYPE)  next_state_s = EXECUTEI;
        else if (op == OP_BEQ)    next_state_s = BEQ;
        else if (op == OP_JAL)    next_state_s = JAL;
`ifdef MAIN_FSM_TRAP_EN
        else                      next_state_s = TRAP;
`else
        else                      next_state_s = FETCH;
`endif
      end
      MEMADR: begin
        if (op == OP_LW) next_state_s = MEMREAD;
        else             next_state_s = MEMWRITE;
      end
      MEMREAD: begin
        if (MemReady) next_state_s = MEMWB;
        else          next_state_s = MEMREAD;
      end
      MEMWRITE: begin
        if (MemReady) next_state_s = FETCH;
        else          next_state_s = MEMWRITE;
      end
      MEMWB:    next_state_s = FETCH;
      EXECUTER: next_state_s = ALUWB;
      EXECUTEI: next_state_s = ALUWB;
      ALUWB:    next_state_s = FETCH;
      BEQ:      next_state_s = FETCH;
      JAL:      next_state_s = ALUWB;
`ifdef MAIN_FSM_TRAP_EN
      TRAP:     next_state_s = TRAP;
`endif
      default:  next_state_s = FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state     (state_r),
    .MemReady  (MemReady),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .InstrDone (InstrDone)
`ifdef MAIN_FSM_TRAP_EN
    ,
    .IllegalOp (IllegalOp)
`endif
  );

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have no parameters; all encodings come from the shared package.
REQ-002 SHALL have port `clk`, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port `op`, input, 7 bits: opcode from the instruction register; stable from DECODE onward.
REQ-005 SHALL have port `MemReady`, input, 1 bit: memory completes the current access this cycle.
REQ-006 SHALL have ports `PCUpdate`, `Branch`, `RegWrite`, `MemWrite`, `IRWrite` and `AdrSrc`, outputs, 1 bit each: datapath strobes and selects.
REQ-007 SHALL have ports `ResultSrc`, `ALUSrcA` and `ALUSrcB`, outputs, 2 bits each: datapath mux selects.
REQ-008 SHALL have port `ALUOp`, output, 2 bits: class code to the downstream ALU decoder (00 add, 01 sub, 10 funct-decoded).
REQ-009 SHALL have port `InstrDone`, output, 1 bit: one-cycle pulse on the final cycle of each instruction.
REQ-010 SHALL have port `IllegalOp`, output, 1 bit: sticky illegal-opcode flag; exists only with the macro in REQ-026.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL (plus TRAP, REQ-026); MemReady gating per REQ-013/016/017 is the only exception.
REQ-012 SHALL drive 0 on every output not listed for the current state.
REQ-013 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=MemReady; stays in FETCH while MemReady=0, else goes to DECODE.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op: 0000011/0100011 to MEMADR; 0110011 to EXECUTER; 0010011 to EXECUTEI; 1100011 to BEQ; 1101111 to JAL; any other to FETCH (no side effects).
REQ-015 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op 0000011 to MEMREAD, otherwise to MEMWRITE.
REQ-016 MEMREAD: AdrSrc=1, ResultSrc=00; holds while MemReady=0; goes to MEMWB when MemReady=1.
REQ-017 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held throughout the wait; goes to FETCH with InstrDone=1 when MemReady=1.
REQ-018 MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1; goes to FETCH.
REQ-019 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB.
REQ-020 ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1; goes to FETCH.
REQ-021 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, InstrDone=1; goes to FETCH.
REQ-022 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; goes to ALUWB.
REQ-023 Latency with MemReady held 1: lw 5 cycles, sw/R/I/jal 4 cycles, beq 3 cycles, unknown op 2 cycles; each wait cycle adds 1.
REQ-024 Outputs SHALL never be X; ALUOp=11 SHALL never be driven.

Reset
REQ-025 While `reset`=1, SHALL force state FETCH and IllegalOp=0; outputs are the FETCH values (IRWrite=PCUpdate=MemReady, InstrDone=0). Reset mid-instruction, including mid-wait, abandons it with no further strobes after deassertion beyond FETCH's.

Configuration
REQ-026 With MAIN_FSM_TRAP_EN defined: an unknown op in DECODE goes to TRAP. TRAP drives all strobes 0, sets IllegalOp=1 and holds until reset. Without the macro: there is no TRAP state and no IllegalOp port; unknown op returns to FETCH per REQ-014.

Structure
REQ-027 Shared package SHALL hold the state encoding (4 bits), opcode constants, ALUOp codes, and ResultSrc/ALUSrcA/ALUSrcB encodings, reused by the ALU decoder.
REQ-028 SHALL be split into a state register/next-state block and one combinational sub-module, main_fsm_outdec (state to control word).

Verification
REQ-029 lw (op=0000011), MemReady=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; InstrDone pulses once.
REQ-030 sw with MemReady=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles; InstrDone only in the final one; 7 cycles total.
REQ-031 beq then jal, back-to-back -> Branch=1 with ALUOp=01 in cycle 3; jal PCUpdate=1 in cycles 1 and 3; RegWrite=1 in cycle 4.
REQ-032 R-type, then I-type -> ALUOp=10 in EXECUTER with ALUSrcB=00, and in EXECUTEI with ALUSrcB=01; each instruction takes 4 cycles.
REQ-033 FETCH with MemReady=0 for 5 cycles -> IRWrite=PCUpdate=0 throughout, then 1 for exactly one cycle.
REQ-034 op=1111111: with the macro -> TRAP, IllegalOp=1 held until reset; without it -> FETCH after DECODE. Also: reset asserted in MEMREAD -> next cycle in FETCH, RegWrite never asserted.
